// File: rtl/echo_delay_ctrl.sv
// rtl/echo_delay_ctrl.sv - UART command decode and echo FIFO flush/fill/run sequencer
module echo_delay_ctrl #(
    parameter int DELAY_W    = 15,
    parameter int DELAY_DEF  = 7996,
    parameter int DELAY_MIN  = 16,
    parameter int DELAY_MAX  = 16000,
    parameter int ATTEN_DEF  = 32767,
    parameter int ATTEN_STEP = 200,
    parameter int FLUSH_CYC  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rs232_data,
    input  logic               rs232_flag,
    input  logic               sample_en,
    input  logic [DELAY_W-1:0] wr_water_level,
    output logic [DELAY_W-1:0] set_delay,
    output logic [15:0]        set_atten,
    output logic               fifo_rst,
    output logic               rd_en,
    output logic               busy,
    output logic               cmd_err
);

    typedef enum logic [1:0] {FLUSH, FILL, RUN} state_t;

    localparam int                 CNT_W    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FLUSH_CYC - 1);
    localparam logic [DELAY_W-1:0] D_DEF    = DELAY_W'(DELAY_DEF);
    localparam logic [DELAY_W-1:0] D_MIN    = DELAY_W'(DELAY_MIN);
    localparam logic [DELAY_W-1:0] D_MAX    = DELAY_W'(DELAY_MAX);
    localparam logic [15:0]        A_DEF    = 16'(ATTEN_DEF);
    localparam logic [15:0]        A_MAX    = 16'd32767;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [DELAY_W-1:0] delay_nxt;
    logic [15:0]        atten_nxt;
    logic               err_nxt;
    logic [16:0]        atten_inc;
    logic signed [17:0] atten_dec;

    assign atten_inc = {1'b0, set_atten} + 17'(ATTEN_STEP);
    assign atten_dec = $signed({2'b00, set_atten}) - $signed(18'(ATTEN_STEP));

    always_comb begin
        delay_nxt = set_delay;
        atten_nxt = set_atten;
        err_nxt   = 1'b0;
        if (rs232_flag) begin
            case (rs232_data)
                8'h11: delay_nxt = (set_delay >= D_MAX) ? D_MAX : set_delay + DELAY_W'(1);
                8'h12: delay_nxt = (set_delay <= D_MIN) ? D_MIN : set_delay - DELAY_W'(1);
                8'h19: atten_nxt = (atten_inc > {1'b0, A_MAX}) ? A_MAX : atten_inc[15:0];
                8'h1A: atten_nxt = atten_dec[17] ? 16'd0 : atten_dec[15:0];
                8'h1F: begin
                    delay_nxt = D_DEF;
                    atten_nxt = A_DEF;
                end
                default: err_nxt = 1'b1;
            endcase
        end
    end

    // A real delay change always wins over the phase sequencing, including a pending FILL->RUN.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (delay_nxt != set_delay) begin
            state_nxt = FLUSH;
            cnt_nxt   = '0;
        end else begin
            case (state)
                FLUSH: begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = FILL;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                FILL: begin
                    if (sample_en && (wr_water_level >= set_delay))
                        state_nxt = RUN;
                end
                RUN:     state_nxt = RUN;
                default: state_nxt = FLUSH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FLUSH;
            cnt       <= '0;
            set_delay <= D_DEF;
            set_atten <= A_DEF;
            cmd_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            set_delay <= delay_nxt;
            set_atten <= atten_nxt;
            cmd_err   <= err_nxt;
        end
    end

    assign fifo_rst = (state == FLUSH);
    assign rd_en    = (state == RUN);
    assign busy     = (state != RUN);

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// tb/tb_echo_delay_ctrl.sv - scoreboard bench for echo_delay_ctrl against a phase-level model
module tb_echo_delay_ctrl;

    localparam int DELAY_W    = 15;
    localparam int DELAY_DEF  = 7996;
    localparam int DELAY_MIN  = 16;
    localparam int DELAY_MAX  = 16000;
    localparam int ATTEN_DEF  = 32767;
    localparam int ATTEN_STEP = 200;
    localparam int FLUSH_CYC  = 4;

    logic               clk;
    logic               rst;
    logic [7:0]         rs232_data;
    logic               rs232_flag;
    logic               sample_en;
    logic [DELAY_W-1:0] wr_water_level;
    logic [DELAY_W-1:0] set_delay;
    logic [15:0]        set_atten;
    logic               fifo_rst;
    logic               rd_en;
    logic               busy;
    logic               cmd_err;

    echo_delay_ctrl #(
        .DELAY_W(DELAY_W), .DELAY_DEF(DELAY_DEF), .DELAY_MIN(DELAY_MIN),
        .DELAY_MAX(DELAY_MAX), .ATTEN_DEF(ATTEN_DEF), .ATTEN_STEP(ATTEN_STEP),
        .FLUSH_CYC(FLUSH_CYC)
    ) dut (
        .clk(clk), .rst(rst), .rs232_data(rs232_data), .rs232_flag(rs232_flag),
        .sample_en(sample_en), .wr_water_level(wr_water_level),
        .set_delay(set_delay), .set_atten(set_atten), .fifo_rst(fifo_rst),
        .rd_en(rd_en), .busy(busy), .cmd_err(cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int d;
        int a;
        bit fr;
        bit rd;
        bit bs;
        bit er;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Model: phase 0=flush, 1=fill, 2=run; m_left counts fifo_rst cycles still owed.
    int m_delay, m_atten, m_phase, m_left;
    bit m_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        checks++;
        if (act !== ex) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, ex);
        end
    endtask

    task automatic step(input bit r, input bit f, input logic [7:0] dat, input bit sen, input int lvl);
        int   nd, na;
        exp_t e;
        @(negedge clk);
        rst            = r;
        rs232_flag     = f;
        rs232_data     = dat;
        sample_en      = sen;
        wr_water_level = DELAY_W'(lvl < 0 ? 0 : lvl);
        if (r) begin
            m_delay = DELAY_DEF;
            m_atten = ATTEN_DEF;
            m_phase = 0;
            m_left  = FLUSH_CYC;
            m_err   = 0;
        end else begin
            nd    = m_delay;
            na    = m_atten;
            m_err = 0;
            if (f) begin
                case (dat)
                    8'h11: nd = (m_delay + 1 > DELAY_MAX) ? DELAY_MAX : m_delay + 1;
                    8'h12: nd = (m_delay - 1 < DELAY_MIN) ? DELAY_MIN : m_delay - 1;
                    8'h19: na = (m_atten + ATTEN_STEP > 32767) ? 32767 : m_atten + ATTEN_STEP;
                    8'h1A: na = (m_atten - ATTEN_STEP < 0) ? 0 : m_atten - ATTEN_STEP;
                    8'h1F: begin
                        nd = DELAY_DEF;
                        na = ATTEN_DEF;
                    end
                    default: m_err = 1;
                endcase
            end
            m_atten = na;
            if (nd != m_delay) begin
                m_delay = nd;
                m_phase = 0;
                m_left  = FLUSH_CYC;
            end else if (m_phase == 0) begin
                m_left--;
                if (m_left == 0) m_phase = 1;
            end else if (m_phase == 1 && sen && lvl >= m_delay) begin
                m_phase = 2;
            end
        end
        e.d  = m_delay;
        e.a  = m_atten;
        e.fr = (m_phase == 0);
        e.rd = (m_phase == 2);
        e.bs = (m_phase != 2);
        e.er = m_err;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 8'h00, 0, 0);
    endtask

    task automatic cmd(input logic [7:0] dat, input int n);
        repeat (n) step(0, 1, dat, 0, 0);
    endtask

    // Feeds samples with a rising water level starting at 'start' once filling begins.
    task automatic fill(input int start, input int budget);
        int lvl;
        bit sen;
        int was_fill;
        lvl = start;
        for (int i = 0; i < budget; i++) begin
            sen      = ($urandom_range(0, 3) != 0);
            was_fill = (m_phase == 1);
            if (m_phase == 0) lvl = start;
            step(0, 0, 8'h00, sen, lvl);
            if (sen && was_fill) lvl++;
            if (m_phase == 2) break;
        end
        idle(2);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("set_delay", 32'(set_delay), 32'(e.d));
                chk("set_atten", 32'(set_atten), 32'(e.a));
                chk("fifo_rst", 32'(fifo_rst), 32'(e.fr));
                chk("rd_en", 32'(rd_en), 32'(e.rd));
                chk("busy", 32'(busy), 32'(e.bs));
                chk("cmd_err", 32'(cmd_err), 32'(e.er));
            end
        end
    end

    initial begin : stimulus
        logic [7:0] cmd_tab [6];
        bit         r, f, sen;
        logic [7:0] dat;
        int         pick, lvl;
        cmd_tab[0] = 8'h11; cmd_tab[1] = 8'h12; cmd_tab[2] = 8'h19;
        cmd_tab[3] = 8'h1A; cmd_tab[4] = 8'h1F; cmd_tab[5] = 8'h55;
        rst = 1'b1; rs232_flag = 1'b0; rs232_data = 8'h00; sample_en = 1'b0; wr_water_level = '0;

        step(1, 1, 8'h11, 1, 0);
        step(1, 0, 8'h00, 0, 0);
        fill(0, 12000);

        cmd(8'h11, 1);
        fill(7990, 300);

        cmd(8'h19, 5);
        cmd(8'h1A, 170);
        idle(3);

        cmd(8'h19, 5);
        cmd(8'h11, 3);
        fill(7990, 300);
        step(1, 0, 8'h00, 0, 0);
        idle(2);
        fill(7980, 300);

        cmd(8'h12, 8000);
        fill(0, 200);
        cmd(8'h12, 1);
        idle(3);
        cmd(8'h1F, 1);
        cmd(8'h11, 8010);
        fill(15990, 300);
        cmd(8'h11, 1);
        idle(3);

        cmd(8'h1F, 1);
        idle(1);
        cmd(8'h12, 1);
        idle(8);
        cmd(8'h1F, 1);
        cmd(8'h55, 1);
        idle(6);

        for (int i = 0; i < 4000; i++) begin
            r    = ($urandom_range(0, 599) == 0);
            f    = ($urandom_range(0, 7) == 0);
            pick = $urandom_range(0, 6);
            dat  = (pick < 6) ? cmd_tab[pick] : 8'($urandom_range(0, 255));
            sen  = $urandom_range(0, 1);
            lvl  = m_delay + $urandom_range(0, 6) - 3;
            step(r, f, dat, sen, lvl);
        end
        idle(2);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected responses left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
